// File: rtl/frame_buf_sched_pkg.sv
// Shared constants for the camera frame-store double-buffer scheduler.
package frame_buf_sched_pkg;

    // Default geometry: 384x216 source, each pixel replicated 5x5 on screen.
    localparam int DEF_SRC_W  = 384;
    localparam int DEF_SRC_H  = 216;
    localparam int DEF_SCALE  = 5;
    localparam int DEF_ADDR_W = 18;

    // Words per bank. Bank 1 starts at this offset.
    localparam int FRAME_WORDS = DEF_SRC_W * DEF_SRC_H;

    // Scheduler state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_FILL = 2'd0;   // first frame after reset; reader has nothing valid
    localparam state_t ST_RUN  = 2'd1;   // writer fills wbank, reader scans rbank
    localparam state_t ST_HOLD = 2'd2;   // wbank complete; waiting for the reader's start of frame

    // Width of a counter that holds 0..n-1. Always at least 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_buf_sched_addr_gen.sv
// Integer-scaling read-address generator. It uses counters and adders only.
// Each source pixel is repeated SCALE times along a line, and each source
// line is repeated SCALE times.
import frame_buf_sched_pkg::*;

module scale_addr_gen #(
    parameter int SRC_W  = DEF_SRC_W,
    parameter int SRC_H  = DEF_SRC_H,
    parameter int SCALE  = DEF_SCALE,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_vid_sof,
    input  logic              i_vid_en,
    input  logic [ADDR_W-1:0] i_rbase,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_valid
);

    localparam int XS_W = cnt_w(SCALE);
    localparam int XP_W = cnt_w(SRC_W);
    localparam int YP_W = cnt_w(SRC_H);

    localparam logic [XS_W-1:0] S_MAX  = XS_W'(SCALE - 1);
    localparam logic [XP_W-1:0] XP_MAX = XP_W'(SRC_W - 1);
    localparam logic [YP_W-1:0] YP_MAX = YP_W'(SRC_H - 1);

    logic [XS_W-1:0]   xs_q, xs_d, xs_e;
    logic [XP_W-1:0]   xp_q, xp_d, xp_e;
    logic [XS_W-1:0]   ys_q, ys_d, ys_e;
    logic [YP_W-1:0]   yp_q, yp_d, yp_e;
    logic [ADDR_W-1:0] lbase_q, lbase_d, lbase_e;
    logic [ADDR_W-1:0] rbase_q, rbase_d, rbase_e;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;

    // Next-state logic. A start of frame zeroes the counters and picks up the new
    // base first. A pixel in that same cycle is then addressed at position 0.
    always_comb begin
        xs_e    = i_vid_sof ? '0 : xs_q;
        xp_e    = i_vid_sof ? '0 : xp_q;
        ys_e    = i_vid_sof ? '0 : ys_q;
        yp_e    = i_vid_sof ? '0 : yp_q;
        lbase_e = i_vid_sof ? '0 : lbase_q;
        rbase_e = i_vid_sof ? i_rbase : rbase_q;

        xs_d    = xs_e;
        xp_d    = xp_e;
        ys_d    = ys_e;
        yp_d    = yp_e;
        lbase_d = lbase_e;
        rbase_d = rbase_e;
        addr_d  = addr_q;
        valid_d = i_vid_en;

        if (i_vid_en) begin
            addr_d = rbase_e + lbase_e + ADDR_W'(xp_e);
            if (xs_e == S_MAX) begin
                xs_d = '0;
                if (xp_e == XP_MAX) begin
                    xp_d = '0;
                    if (ys_e == S_MAX) begin
                        ys_d = '0;
                        if (yp_e == YP_MAX) begin
                            yp_d    = '0;
                            lbase_d = '0;
                        end else begin
                            yp_d    = yp_e + 1'b1;
                            lbase_d = lbase_e + ADDR_W'(SRC_W);
                        end
                    end else begin
                        ys_d = ys_e + 1'b1;
                    end
                end else begin
                    xp_d = xp_e + 1'b1;
                end
            end else begin
                xs_d = xs_e + 1'b1;
            end
        end
    end

    // Counter and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            xs_q    <= '0;
            xp_q    <= '0;
            ys_q    <= '0;
            yp_q    <= '0;
            lbase_q <= '0;
            rbase_q <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            xs_q    <= xs_d;
            xp_q    <= xp_d;
            ys_q    <= ys_d;
            yp_q    <= yp_d;
            lbase_q <= lbase_d;
            rbase_q <= rbase_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign o_rd_addr  = addr_q;
    assign o_rd_valid = valid_q;

endmodule

// File: rtl/frame_buf_sched.sv
// Double-buffer (ping-pong) scheduler between the capture writer and the VGA reader.
//
// state | meaning
// FILL  | first frame after reset; reader has no complete frame (display black)
// RUN   | writer fills wbank while reader scans rbank
// HOLD  | wbank complete; writer stalled until the next VGA start of frame
import frame_buf_sched_pkg::*;

module frame_buf_sched #(
    parameter int SRC_W  = DEF_SRC_W,
    parameter int SRC_H  = DEF_SRC_H,
    parameter int SCALE  = DEF_SCALE,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_frame_start,
    input  logic              i_wr_frame_done,
    output logic              o_wr_allow,
    output logic [ADDR_W-1:0] o_wr_base,
    input  logic              i_vid_sof,
    input  logic              i_vid_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_valid,
    output logic              o_rd_active,
    output logic [15:0]       o_skip_cnt,
    output logic              o_err
);

    localparam int BANK_WORDS = SRC_W * SRC_H;

    state_t            state_q, state_d;
    logic              wbank_q, wbank_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d;
    logic              rd_active_q, rd_active_d;
    logic [15:0]       skip_cnt_q, skip_cnt_d;
    logic              err_q, err_d;
    logic              swap;
    logic [ADDR_W-1:0] rbase_next;

    function automatic logic [ADDR_W-1:0] bank_base(input logic bank);
        return bank ? ADDR_W'(BANK_WORDS) : '0;
    endfunction

    // Scheduler FSM, bank swap, skip counter and error flag.
    // rbase_next already includes a swap made in this cycle, so a start of frame
    // that causes a swap begins scanning from the bank just finished.
    always_comb begin
        state_d     = state_q;
        wbank_d     = wbank_q;
        rd_active_d = rd_active_q;
        skip_cnt_d  = skip_cnt_q;
        err_d       = err_q;
        swap        = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (i_wr_frame_done) state_d = ST_HOLD;
            end
            ST_RUN: begin
                if (i_wr_frame_done) begin
                    if (i_vid_sof) swap = 1'b1;
                    else           state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_vid_sof) begin
                    swap    = 1'b1;
                    state_d = ST_RUN;
                end
                if (i_wr_frame_start && (skip_cnt_q != 16'hFFFF))
                    skip_cnt_d = skip_cnt_q + 16'd1;
                if (i_wr_frame_done)
                    err_d = 1'b1;
            end
            default: state_d = ST_FILL;
        endcase

        if (swap) begin
            wbank_d     = ~wbank_q;
            rd_active_d = 1'b1;
        end

        wr_base_d  = bank_base(wbank_d);
        rbase_next = bank_base(~wbank_d);
    end

    // Scheduler registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_FILL;
            wbank_q     <= 1'b0;
            wr_base_q   <= '0;
            rd_active_q <= 1'b0;
            skip_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wbank_q     <= wbank_d;
            wr_base_q   <= wr_base_d;
            rd_active_q <= rd_active_d;
            skip_cnt_q  <= skip_cnt_d;
            err_q       <= err_d;
        end
    end

    scale_addr_gen #(
        .SRC_W  (SRC_W),
        .SRC_H  (SRC_H),
        .SCALE  (SCALE),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_vid_sof  (i_vid_sof),
        .i_vid_en   (i_vid_en),
        .i_rbase    (rbase_next),
        .o_rd_addr  (o_rd_addr),
        .o_rd_valid (o_rd_valid)
    );

    assign o_wr_allow  = (state_q != ST_HOLD);
    assign o_wr_base   = wr_base_q;
    assign o_rd_active = rd_active_q;
    assign o_skip_cnt  = skip_cnt_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Directed bench for frame_buf_sched using a small 8x4 source and 2x scaling.
module tb_frame_buf_sched;

    localparam int SRC_W   = 8;
    localparam int SRC_H   = 4;
    localparam int SCALE   = 2;
    localparam int ADDR_W  = 18;
    localparam int FW      = SRC_W * SRC_H;
    localparam int LINE_PX = SRC_W * SCALE;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_start, wr_done, vid_sof, vid_en;
    logic              wr_allow, rd_valid, rd_active, err;
    logic [ADDR_W-1:0] wr_base, rd_addr;
    logic [15:0]       skip_cnt;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int m_px, m_py, m_base, exp_rbase;

    always #5 clk = ~clk;

    frame_buf_sched #(
        .SRC_W  (SRC_W),
        .SRC_H  (SRC_H),
        .SCALE  (SCALE),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_wr_frame_start (wr_start),
        .i_wr_frame_done  (wr_done),
        .o_wr_allow       (wr_allow),
        .o_wr_base        (wr_base),
        .i_vid_sof        (vid_sof),
        .i_vid_en         (vid_en),
        .o_rd_addr        (rd_addr),
        .o_rd_valid       (rd_valid),
        .o_rd_active      (rd_active),
        .o_skip_cnt       (skip_cnt),
        .o_err            (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one clock of inputs. The expected address comes from the divide-based
    // reference. It is compared when the DUT flags the pixel one cycle later.
    task automatic cyc(input logic sof, input logic en, input logic done, input logic start);
        int exp_a;
        vid_sof  = sof;
        vid_en   = en;
        wr_done  = done;
        wr_start = start;
        if (sof) begin
            m_px   = 0;
            m_py   = 0;
            m_base = exp_rbase;
        end
        if (en) begin
            exp_q.push_back(m_base + (m_py / SCALE) * SRC_W + m_px / SCALE);
            m_px++;
            if (m_px == LINE_PX) begin
                m_px = 0;
                m_py++;
                if (m_py == SRC_H * SCALE) m_py = 0;
            end
        end
        tick();
        vid_sof  = 1'b0;
        vid_en   = 1'b0;
        wr_done  = 1'b0;
        wr_start = 1'b0;
        chk("rd_valid", 32'(rd_valid), 32'(en));
        if (rd_valid === 1'b1 && exp_q.size() > 0) begin
            exp_a = exp_q.pop_front();
            chk("rd_addr", 32'(rd_addr), 32'(exp_a));
        end
    endtask

    // Active lines that follow a start of frame. Two blank clocks come after
    // each line. first_done skips pixel 0 of the first line, for the case
    // where that pixel was already sent together with the start of frame.
    task automatic scan_rest(input int lines, input logic first_done);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < LINE_PX; p++)
                if (!(l == 0 && p == 0 && first_done)) cyc(1'b0, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; wr_start = 1'b0; wr_done = 1'b0; vid_sof = 1'b0; vid_en = 1'b0;
        m_px = 0; m_py = 0; m_base = 0; exp_rbase = 0;
        tick();
        tick();
        chk("rst_rd_addr",   32'(rd_addr),   32'd0);
        chk("rst_rd_valid",  32'(rd_valid),  32'd0);
        chk("rst_rd_active", 32'(rd_active), 32'd0);
        chk("rst_wr_base",   32'(wr_base),   32'd0);
        chk("rst_wr_allow",  32'(wr_allow),  32'd1);
        chk("rst_skip_cnt",  32'(skip_cnt),  32'd0);
        chk("rst_err",       32'(err),       32'd0);
        rst = 1'b0;
        tick();

        // Two VGA frames in FILL with no done pulse. The reader points at bank 1.
        exp_rbase = FW;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        scan_rest(2, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        scan_rest(1, 1'b1);
        chk("fill_rd_active", 32'(rd_active), 32'd0);
        chk("fill_wr_allow",  32'(wr_allow),  32'd1);
        chk("fill_wr_base",   32'(wr_base),   32'd0);

        // done in FILL leads to HOLD. Three refused starts follow, then a done in HOLD.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("hold_wr_allow", 32'(wr_allow), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("hold_skip_cnt", 32'(skip_cnt), 32'd3);
        chk("hold_wr_allow2", 32'(wr_allow), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("hold_err", 32'(err), 32'd1);
        chk("hold_err_state", 32'(wr_allow), 32'd0);

        // The start of frame in HOLD swaps banks. The reader now scans bank 0.
        exp_rbase = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("swap1_wr_allow",  32'(wr_allow),  32'd1);
        chk("swap1_wr_base",   32'(wr_base),   32'(FW));
        chk("swap1_rd_active", 32'(rd_active), 32'd1);
        chk("swap1_err_sticky", 32'(err), 32'd1);
        scan_rest(3, 1'b0);

        // RUN, with done, start of frame and a pixel in the same cycle: swap at once.
        exp_rbase = FW;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("swap2_first_addr", 32'(rd_addr),  32'(FW));
        chk("swap2_wr_allow",   32'(wr_allow), 32'd1);
        chk("swap2_wr_base",    32'(wr_base),  32'd0);
        scan_rest(2, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("run_skip_hold", 32'(skip_cnt), 32'd3);

        // A done in RUN leads to HOLD. Swap again, then apply reset partway through a line.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("run_to_hold", 32'(wr_allow), 32'd0);
        exp_rbase = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("swap3_wr_base", 32'(wr_base), 32'(FW));
        for (int p = 0; p < 5; p++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        vid_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rd_addr",   32'(rd_addr),   32'd0);
        chk("mid_rd_valid",  32'(rd_valid),  32'd0);
        chk("mid_rd_active", 32'(rd_active), 32'd0);
        chk("mid_wr_base",   32'(wr_base),   32'd0);
        chk("mid_wr_allow",  32'(wr_allow),  32'd1);
        chk("mid_skip_cnt",  32'(skip_cnt),  32'd0);
        chk("mid_err",       32'(err),       32'd0);
        vid_en = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();

        // After reset, the DUT is back in FILL and the reader points at bank 1.
        exp_rbase = FW;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        scan_rest(1, 1'b0);
        chk("post_rst_active", 32'(rd_active), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
